// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the byte-serialising data-memory controller.
package data_mem_ctrl_pkg;

    localparam int          MEM_BYTE_W   = 8;
    localparam int          DEF_READ_LAT = 1;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_DRAIN = 3'd2,
        ST_RD_DONE  = 3'd3,
        ST_WR       = 3'd4
    } state_e;

    function automatic logic [MEM_BYTE_W-1:0] lane_byte(input logic [31:0] word,
                                                        input logic [1:0]  lane);
        case (lane)
            2'd0:    lane_byte = word[7:0];
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            2'd3:    lane_byte = word[31:24];
            default: lane_byte = word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_rd_shift.sv
// Delay line of {valid, lane} tags matching the RAM read latency; the last
// stage tells the controller which lane mem_d_i belongs to this cycle.
module mem_rd_shift #(
    parameter int READ_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [1:0] lane_i,
    output logic       cap_o,
    output logic [1:0] cap_lane_o
);

    logic [READ_LAT-1:0] valid_q;
    logic [1:0]          lane_q [READ_LAT];

    // Tag pipeline; reset drops every in-flight tag
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= {READ_LAT{1'b0}};
            for (int i = 0; i < READ_LAT; i++) begin
                lane_q[i] <= 2'd0;
            end
        end else begin
            valid_q[0] <= push_i;
            lane_q[0]  <= lane_i;
            for (int i = 1; i < READ_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                lane_q[i]  <= lane_q[i-1];
            end
        end
    end

    assign cap_o      = valid_q[READ_LAT-1];
    assign cap_lane_o = lane_q[READ_LAT-1];

endmodule

// File: rtl/data_mem_ctrl.sv
// Serialises ME-stage word reads and masked writes into byte transactions on
// a byte-wide synchronous RAM; reads return an assembled little-endian word.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r_enable_i,
    input  logic                  w_enable_i,
    input  logic [3:0]            w_mask_i,
    input  logic [31:0]           w_data_i,
    input  logic [31:0]           addr_i,
    output logic                  ram_busy,
    output logic                  ram_done,
    output logic [31:0]           ram_r_data,
    output logic [31:0]           mem_a_o,
    output logic [MEM_BYTE_W-1:0] mem_d_o,
    output logic                  mem_wr_o,
    input  logic [MEM_BYTE_W-1:0] mem_d_i
);

    state_e                state_q, state_d;
    logic                  busy_q, busy_d, done_q, done_d, mem_wr_q, mem_wr_d;
    logic [31:0]           r_data_q, r_data_d, mem_a_q, mem_a_d, wdata_q, wdata_d;
    logic [MEM_BYTE_W-1:0] mem_d_q, mem_d_d;
    logic [23:0]           word_q, word_d;
    logic [29:0]           base_q, base_d;
    logic [3:0]            rem_q, rem_d, sel_mask_s;
    logic [1:0]            idx_q, idx_d, sel_lane_s, cap_lane_s, idx_inc_s;
    logic                  push_s, cap_s, unused_s;

    assign unused_s  = ^addr_i[1:0];
    assign idx_inc_s = idx_q + 2'd1;

    mem_rd_shift #(.READ_LAT(READ_LAT)) u_rd_shift (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_s),
        .lane_i     (idx_q),
        .cap_o      (cap_s),
        .cap_lane_o (cap_lane_s)
    );

    // Lowest pending write lane: the new request's mask in IDLE, else what remains
    always_comb begin
        if (state_q == ST_IDLE) begin
            sel_mask_s = w_mask_i;
        end else begin
            sel_mask_s = rem_q;
        end
        casez (sel_mask_s)
            4'b???1: sel_lane_s = 2'd0;
            4'b??10: sel_lane_s = 2'd1;
            4'b?100: sel_lane_s = 2'd2;
            4'b1000: sel_lane_s = 2'd3;
            default: sel_lane_s = 2'd0;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mem_wr_d = 1'b0;
        r_data_d = r_data_q;
        mem_a_d  = mem_a_q;
        mem_d_d  = mem_d_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        base_d   = base_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        push_s   = 1'b0;

        if (cap_s) begin
            case (cap_lane_s)
                2'd0:    word_d[7:0]   = mem_d_i;
                2'd1:    word_d[15:8]  = mem_d_i;
                2'd2:    word_d[23:16] = mem_d_i;
                default: word_d        = word_q;
            endcase
        end else begin
            word_d = word_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (r_enable_i && !done_q) begin
                    state_d = ST_RD_ISSUE;
                    busy_d  = 1'b1;
                    base_d  = addr_i[31:2];
                    idx_d   = 2'd0;
                    mem_a_d = {addr_i[31:2], 2'b00};
                end else if (w_enable_i && !done_q && (w_mask_i != 4'b0000)) begin
                    state_d  = ST_WR;
                    busy_d   = 1'b1;
                    base_d   = addr_i[31:2];
                    wdata_d  = w_data_i;
                    rem_d    = w_mask_i & ~(4'b0001 << sel_lane_s);
                    mem_a_d  = {addr_i[31:2], sel_lane_s};
                    mem_d_d  = lane_byte(w_data_i, sel_lane_s);
                    mem_wr_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                push_s = 1'b1;
                if (idx_q == 2'd3) begin
                    state_d = ST_RD_DRAIN;
                end else begin
                    idx_d   = idx_inc_s;
                    mem_a_d = {base_q, idx_inc_s};
                end
            end
            ST_RD_DRAIN: begin
                // Lane 3 is always the last tag out of the delay line
                if (cap_s && (cap_lane_s == 2'd3)) begin
                    state_d  = ST_RD_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    r_data_d = {mem_d_i, word_q};
                end else begin
                    state_d = ST_RD_DRAIN;
                end
            end
            ST_RD_DONE: begin
                state_d = ST_IDLE;
            end
            ST_WR: begin
                if (rem_q != 4'b0000) begin
                    rem_d    = rem_q & ~(4'b0001 << sel_lane_s);
                    mem_a_d  = {base_q, sel_lane_s};
                    mem_d_d  = lane_byte(wdata_q, sel_lane_s);
                    mem_wr_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mem_wr_q <= 1'b0;
            r_data_q <= ZERO_WORD;
            mem_a_q  <= ZERO_WORD;
            mem_d_q  <= {MEM_BYTE_W{1'b0}};
            wdata_q  <= ZERO_WORD;
            word_q   <= 24'h00_0000;
            base_q   <= 30'd0;
            rem_q    <= 4'b0000;
            idx_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mem_wr_q <= mem_wr_d;
            r_data_q <= r_data_d;
            mem_a_q  <= mem_a_d;
            mem_d_q  <= mem_d_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            base_q   <= base_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
        end
    end

    assign ram_busy   = busy_q;
    assign ram_done   = done_q;
    assign ram_r_data = r_data_q;
    assign mem_a_o    = mem_a_q;
    assign mem_d_o    = mem_d_q;
    assign mem_wr_o   = mem_wr_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench: two controllers (read latency 1 and 3), each on its own behavioural
// byte RAM, checked against a word-level memory model and cycle-timing rules.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic load;
    always #5 clk = ~clk;

    logic        r_en     [2];
    logic        w_en     [2];
    logic [3:0]  w_mask   [2];
    logic [31:0] w_data   [2];
    logic [31:0] addr     [2];
    logic        busy     [2];
    logic        done     [2];
    logic [31:0] rdata    [2];
    logic [31:0] mem_a    [2];
    logic [7:0]  mem_dout [2];
    logic        mem_wr   [2];
    logic [7:0]  mem_din  [2];

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  model     [2][4096];
    logic [31:0] last_word [2];

    function automatic logic [7:0] init_byte(input logic [11:0] a);
        case (a)
            12'h100: init_byte = 8'h11;
            12'h101: init_byte = 8'h22;
            12'h102: init_byte = 8'h33;
            12'h103: init_byte = 8'h44;
            default: init_byte = a[7:0] ^ {a[11:8], 4'hA};
        endcase
    endfunction

    function automatic int lat(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_unit
        localparam int L = (g == 0) ? 1 : 3;
        logic [7:0] ram  [4096];
        logic [7:0] pipe [4];

        data_mem_ctrl #(.READ_LAT(L)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .r_enable_i (r_en[g]),
            .w_enable_i (w_en[g]),
            .w_mask_i   (w_mask[g]),
            .w_data_i   (w_data[g]),
            .addr_i     (addr[g]),
            .ram_busy   (busy[g]),
            .ram_done   (done[g]),
            .ram_r_data (rdata[g]),
            .mem_a_o    (mem_a[g]),
            .mem_d_o    (mem_dout[g]),
            .mem_wr_o   (mem_wr[g]),
            .mem_d_i    (mem_din[g])
        );

        // Byte RAM: data for an address appears L cycles after it is presented
        always @(posedge clk) begin
            if (load) begin
                for (int i = 0; i < 4096; i++) ram[i] <= init_byte(12'(i));
            end else if (mem_wr[g]) begin
                ram[mem_a[g][11:0]] <= mem_dout[g];
            end
            pipe[0] <= ram[mem_a[g][11:0]];
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_din[g] = pipe[L-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs(input int u);
        r_en[u] = 1'b0; w_en[u] = 1'b0; w_mask[u] = 4'h0; w_data[u] = 32'h0; addr[u] = 32'h0;
    endtask

    task automatic junk(input int u);
        r_en[u]   = 1'($urandom_range(0, 1));
        w_en[u]   = 1'($urandom_range(0, 1));
        w_mask[u] = 4'($urandom_range(0, 15));
        w_data[u] = $urandom;
        addr[u]   = $urandom;
    endtask

    function automatic logic [31:0] model_word(input int u, input logic [31:0] a);
        int w;
        w = int'(a[11:2]) * 4;
        return {model[u][w+3], model[u][w+2], model[u][w+1], model[u][w]};
    endfunction

    // Called mid-cycle T; request sampled at the edge ending T
    task automatic do_read(input int u, input logic [31:0] a, input bit also_w);
        int          lt;
        logic [31:0] base, exp_w;
        lt    = lat(u);
        base  = {a[31:2], 2'b00};
        exp_w = model_word(u, a);
        r_en[u] = 1'b1; addr[u] = a; w_en[u] = also_w; w_mask[u] = 4'hF; w_data[u] = $urandom;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= 5 + lt; c++) begin
            if (c <= 4) chk("rd_addr", mem_a[u], base + 32'(c - 1));
            chk("rd_no_wr", {31'd0, mem_wr[u]}, 32'd0);
            chk("rd_busy", {31'd0, busy[u]}, {31'd0, c <= 4 + lt});
            chk("rd_done", {31'd0, done[u]}, {31'd0, c == 5 + lt});
            if (c == 5 + lt) chk("rd_data", rdata[u], exp_w);
            else             chk("rd_hold", rdata[u], last_word[u]);
            junk(u);
            @(negedge clk);
        end
        idle_inputs(u);
        chk("rd_after", {30'd0, busy[u], done[u]}, 32'd0);
        last_word[u] = exp_w;
    endtask

    task automatic do_write(input int u, input logic [31:0] a, input logic [3:0] mask,
                            input logic [31:0] data);
        int w;
        w = int'(a[11:2]) * 4;
        r_en[u] = 1'b0; w_en[u] = 1'b1; w_mask[u] = mask; w_data[u] = data; addr[u] = a;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                chk("wr_strobe", {31'd0, mem_wr[u]}, 32'd1);
                chk("wr_addr", mem_a[u], {a[31:2], 2'(k)});
                chk("wr_data", {24'd0, mem_dout[u]}, {24'd0, data[8*k +: 8]});
                chk("wr_busy", {31'd0, busy[u]}, 32'd1);
                chk("wr_no_done", {31'd0, done[u]}, 32'd0);
                chk("wr_rdata_hold", rdata[u], last_word[u]);
                model[u][w+k] = data[8*k +: 8];
                junk(u);
                @(negedge clk);
            end
        end
        idle_inputs(u);
        chk("wr_end_busy", {31'd0, busy[u]}, 32'd0);
        chk("wr_end_strobe", {31'd0, mem_wr[u]}, 32'd0);
        chk("wr_end_done", {31'd0, done[u]}, 32'd0);
    endtask

    task automatic reset_mid_read(input int u, input logic [31:0] a);
        r_en[u] = 1'b1; addr[u] = a;
        @(posedge clk);
        @(negedge clk);
        idle_inputs(u);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy[u]}, 32'd0);
        chk("rst_done", {31'd0, done[u]}, 32'd0);
        chk("rst_wr", {31'd0, mem_wr[u]}, 32'd0);
        chk("rst_addr", mem_a[u], 32'd0);
        chk("rst_wdata", {24'd0, mem_dout[u]}, 32'd0);
        chk("rst_rdata", rdata[u], 32'd0);
        last_word[0] = 32'd0;
        last_word[1] = 32'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rst_no_done", {31'd0, done[u]}, 32'd0);
            chk("rst_no_busy", {31'd0, busy[u]}, 32'd0);
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            idle_inputs(u);
            last_word[u] = 32'd0;
            for (int i = 0; i < 4096; i++) model[u][i] = init_byte(12'(i));
        end
        rst  = 1'b1;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset_outputs", {29'd0, busy[u], done[u], mem_wr[u]}, 32'd0);
            chk("reset_rdata", rdata[u], 32'd0);
            chk("reset_addr", mem_a[u], 32'd0);
            chk("reset_wdata", {24'd0, mem_dout[u]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        do_read(0, 32'h0000_0100, 1'b0);
        chk("lw100_word", rdata[0], 32'h4433_2211);
        do_write(0, 32'h0000_0203, 4'b1000, 32'hABAB_ABAB);
        do_write(0, 32'h0000_0300, 4'b1111, 32'hDEAD_BEEF);
        do_read(0, 32'h0000_0300, 1'b0);
        chk("sw_lw300_word", rdata[0], 32'hDEAD_BEEF);
        do_write(0, 32'h0000_0402, 4'b1100, 32'h5678_5678);
        do_read(0, 32'h0000_0400, 1'b1);
        reset_mid_read(0, 32'h0000_0100);
        do_read(0, 32'h0000_0100, 1'b0);
        chk("lw100_after_rst", rdata[0], 32'h4433_2211);

        do_read(1, 32'h0000_0100, 1'b0);
        chk("lat3_word", rdata[1], 32'h4433_2211);
        do_write(1, 32'h0000_0500, 4'b0000, 32'h1234_5678);
        do_read(1, 32'h0000_0500, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int          u;
            logic [31:0] a;
            u = int'($urandom_range(0, 1));
            a = 32'h0000_0100 + 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 1) == 0) begin
                do_read(u, a, 1'($urandom_range(0, 1)));
            end else begin
                do_write(u, a | 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
